sr_write_arb: RTL
=================

SR_WRITE_ARB -- requirements
Module: sr_write_arb

Interface
REQ-001 SHALL have parameter DW, default 48, SR data width (matches SIZE_ADDR).
REQ-002 SHALL have parameter AW, default 4, SR index width.
REQ-003 SHALL have parameter SSP_IDX, default 1, SR index of the supervisor stack pointer.
REQ-004 iw_clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 iw_rst  in  1  reset, synchronous, active-high.
REQ-006 iw_trap_valid / iw_trap_addr / iw_trap_data  in  1/AW/DW  trap-unit SR write request.
REQ-007 ow_trap_ready  out  1  trap write accepted this cycle.
REQ-008 iw_wb_valid / iw_wb_addr / iw_wb_data  in  1/AW/DW  pipeline writeback SR write request.
REQ-009 ow_wb_ready  out  1  writeback accepted this cycle.
REQ-010 iw_adj_valid / iw_adj_dec / iw_adj_amt  in  1/1/12  SSP adjust request; dec=1 subtract, amt zero-extended to DW.
REQ-011 ow_adj_ready  out  1  adjust request accepted (FSM idle).
REQ-012 ow_adj_done / ow_adj_fault / ow_adj_result  out  1/1/DW  completion pulse, fault flag, new SSP value.
REQ-013 ow_rf_raddr  out  AW  SR read-port index; iw_rf_rdata  in  DW  combinational read data.
REQ-014 ow_rf_we / ow_rf_waddr / ow_rf_wdata  out  1/AW/DW  single SR write port.

Function
REQ-015 SHALL issue at most one SR write per cycle; write outputs are combinational from the granted source.
REQ-016 A transfer SHALL occur when valid and ready are both high; requesters SHALL NOT make valid depend on ready.
REQ-017 Trap SHALL have fixed highest priority: ow_trap_ready = iw_trap_valid.
REQ-018 Writeback and adjust-write SHALL share lower priority round-robin via 1-bit pointer; on contention the pointed-to source wins.
REQ-019 Pointer SHALL update on every wb or adjust-write grant to point at the other source; unchanged on trap grant or idle.
REQ-020 ow_wb_ready SHALL be 0 in any cycle the trap is granted or the adjust-write wins.
REQ-021 Adjust FSM states: IDLE, READ, CHECK, WRITE.
REQ-022 IDLE: ow_adj_ready=1; on iw_adj_valid latch dec and amt, go READ.
REQ-023 READ: ow_rf_raddr=SSP_IDX; capture iw_rf_rdata as old value; go CHECK.
REQ-024 CHECK: compute old+amt or old-amt at DW bits; dec with amt>old or inc with carry-out -> fault: pulse done=1, fault=1, result=old, no write, go IDLE; else go WRITE.
REQ-025 WRITE: request write of new value to SSP_IDX; on grant pulse done=1, fault=0, result=new next cycle, go IDLE.
REQ-026 WRITE hazard: if trap or wb writes SSP_IDX while FSM is in CHECK or WRITE, FSM SHALL discard its value and return to READ (no write, no done).
REQ-027 Hazard check SHALL use granted writes only; a wb held off by ready=0 is not a hazard.
REQ-028 ow_rf_raddr SHALL be SSP_IDX in all states (read port dedicated to this block).
REQ-029 Minimum adjust latency, no contention: accept cycle T, write at T+3, done at T+4.
REQ-030 ow_adj_done SHALL be a single-cycle pulse; ow_adj_result and ow_adj_fault hold until the next done.
REQ-031 New adjust request SHALL NOT be accepted in the done-pulse cycle unless FSM is IDLE that cycle.

Reset
REQ-032 On iw_rst sampled high: FSM=IDLE, pointer=wb, ow_adj_done=0, ow_adj_fault=0, ow_adj_result=0, latched dec/amt=0.
REQ-033 While iw_rst high: ow_rf_we=0 and all ready outputs=0.
REQ-034 Reset mid-adjust SHALL abandon the operation: no SR write, no done pulse.

Verification
REQ-035 SSP=0xFFF, adj dec amt=0x10, no other traffic -> rf write SSP_IDX=0xFEF at T+3, done=1 fault=0 result=0xFEF at T+4.
REQ-036 SSP=0x8, adj dec amt=0x10 -> done=1 fault=1 result=0x8 at T+3, ow_rf_we never 1.
REQ-037 trap(addr 3, 0xA) and wb(addr 4, 0xB) valid same cycle -> only addr 3 written; wb written next cycle.
REQ-038 wb valid continuously, adjust reaches WRITE -> writes alternate wb, adj, wb; neither starves beyond 1 cycle.
REQ-039 Adjust in CHECK, wb writes SSP_IDX=0x500 -> FSM re-reads, final write 0x500+/-amt, single done pulse.
REQ-040 iw_rst asserted during WRITE with wb idle -> no write, no done; after release ow_adj_ready=1.

Source files
------------

// File: rtl/sr_write_arb.sv
// SR write-port arbiter: trap has fixed top priority, writeback and the SSP adjust
// engine share the remaining slot round-robin. Also holds the SSP read/check/write FSM.
module sr_write_arb #(
    parameter int DW      = 48,
    parameter int AW      = 4,
    parameter int SSP_IDX = 1
) (
    input  logic          iw_clk,
    input  logic          iw_rst,

    input  logic          iw_trap_valid,
    input  logic [AW-1:0] iw_trap_addr,
    input  logic [DW-1:0] iw_trap_data,
    output logic          ow_trap_ready,

    input  logic          iw_wb_valid,
    input  logic [AW-1:0] iw_wb_addr,
    input  logic [DW-1:0] iw_wb_data,
    output logic          ow_wb_ready,

    input  logic          iw_adj_valid,
    input  logic          iw_adj_dec,
    input  logic [11:0]   iw_adj_amt,
    output logic          ow_adj_ready,
    output logic          ow_adj_done,
    output logic          ow_adj_fault,
    output logic [DW-1:0] ow_adj_result,

    output logic [AW-1:0] ow_rf_raddr,
    input  logic [DW-1:0] iw_rf_rdata,

    output logic          ow_rf_we,
    output logic [AW-1:0] ow_rf_waddr,
    output logic [DW-1:0] ow_rf_wdata
);

    localparam logic [AW-1:0] SSP_ADDR = AW'(SSP_IDX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_WRITE
    } adj_state_e;

    // Bit DW of the result flags overflow on increment and borrow on decrement.
    function automatic logic [DW:0] ssp_adjust(input logic [DW-1:0] old_val,
                                               input logic          dec,
                                               input logic [11:0]   amt);
        logic [DW:0] amt_ext;
        amt_ext = (DW+1)'(amt);
        if (dec) begin
            return {1'b0, old_val} - amt_ext;
        end
        return {1'b0, old_val} + amt_ext;
    endfunction

    adj_state_e    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          dec_q, dec_d;
    logic [11:0]   amt_q, amt_d;
    logic [DW-1:0] old_q, old_d;
    logic [DW-1:0] new_q, new_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [DW-1:0] result_q, result_d;

    logic          adj_req;
    logic          trap_gnt;
    logic          wb_gnt;
    logic          adj_gnt;
    logic          ssp_hit;
    logic [DW:0]   adj_sum;

    // ptr_q == 0 favours writeback on contention, 1 favours the adjust write.
    always_comb begin
        adj_req  = (state_q == ST_WRITE);
        trap_gnt = 1'b0;
        wb_gnt   = 1'b0;
        adj_gnt  = 1'b0;
        if (!iw_rst) begin
            if (iw_trap_valid) begin
                trap_gnt = 1'b1;
            end else if (iw_wb_valid && adj_req) begin
                if (ptr_q) begin
                    adj_gnt = 1'b1;
                end else begin
                    wb_gnt = 1'b1;
                end
            end else begin
                wb_gnt  = iw_wb_valid;
                adj_gnt = adj_req;
            end
        end
        ssp_hit = (trap_gnt && (iw_trap_addr == SSP_ADDR)) ||
                  (wb_gnt && (iw_wb_addr == SSP_ADDR));
    end

    always_comb begin
        ow_rf_we    = trap_gnt | wb_gnt | adj_gnt;
        ow_rf_waddr = '0;
        ow_rf_wdata = '0;
        if (trap_gnt) begin
            ow_rf_waddr = iw_trap_addr;
            ow_rf_wdata = iw_trap_data;
        end else if (wb_gnt) begin
            ow_rf_waddr = iw_wb_addr;
            ow_rf_wdata = iw_wb_data;
        end else if (adj_gnt) begin
            ow_rf_waddr = SSP_ADDR;
            ow_rf_wdata = new_q;
        end
    end

    assign ow_trap_ready = trap_gnt;
    assign ow_wb_ready   = wb_gnt;
    assign ow_adj_ready  = !iw_rst && (state_q == ST_IDLE);
    assign ow_adj_done   = done_q;
    assign ow_adj_fault  = fault_q;
    assign ow_adj_result = result_q;
    assign ow_rf_raddr   = SSP_ADDR;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        dec_d    = dec_q;
        amt_d    = amt_q;
        old_d    = old_q;
        new_d    = new_q;
        done_d   = 1'b0;
        fault_d  = fault_q;
        result_d = result_q;
        adj_sum  = ssp_adjust(old_q, dec_q, amt_q);

        if (wb_gnt) begin
            ptr_d = 1'b1;
        end else if (adj_gnt) begin
            ptr_d = 1'b0;
        end

        // A granted foreign write to the SSP after the read makes old_q stale.
        unique case (state_q)
            ST_IDLE: begin
                if (iw_adj_valid) begin
                    dec_d   = iw_adj_dec;
                    amt_d   = iw_adj_amt;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                old_d   = iw_rf_rdata;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (ssp_hit) begin
                    state_d = ST_READ;
                end else if (adj_sum[DW]) begin
                    done_d   = 1'b1;
                    fault_d  = 1'b1;
                    result_d = old_q;
                    state_d  = ST_IDLE;
                end else begin
                    new_d   = adj_sum[DW-1:0];
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ssp_hit) begin
                    state_d = ST_READ;
                end else if (adj_gnt) begin
                    done_d   = 1'b1;
                    fault_d  = 1'b0;
                    result_d = new_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            dec_q    <= 1'b0;
            amt_q    <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dec_q    <= dec_d;
            amt_q    <= amt_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            result_q <= result_d;
        end
    end

    // Operand holding registers are only meaningful once the FSM has advanced past them.
    always_ff @(posedge iw_clk) begin
        old_q <= old_d;
        new_q <= new_d;
    end

endmodule
